// File: rtl/note_pkg.sv
// Shared types and constants for the note player: state encoding, field widths
// and the frequency table contents used by the step-size ROM.
package note_pkg;

    typedef enum logic [1:0] {
        NP_IDLE = 2'd0,
        NP_LOAD = 2'd1,
        NP_PLAY = 2'd2,
        NP_DONE = 2'd3
    } np_state_t;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int SAMPLE_W = 16;
    localparam int ROM_DEPTH = 1 << NOTE_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

    // Phase step for a note index, scaled for a 20-bit accumulator at 48 kHz.
    // Index 49 is A4 (440 Hz); each step of 12 is one octave. The top octave
    // (A5..G#6) is tabulated and lower octaves are derived by halving.
    // Index 63 is a near-full-scale test tone that wraps the accumulator fast.
    function automatic logic [31:0] np_rom_step(input int unsigned idx);
        logic [31:0] base;
        int unsigned semi;
        int unsigned oct;
        base = 32'd0;
        if (idx == 0) begin
            return 32'd0;
        end
        if (idx == 63) begin
            return 32'h000F_0000;
        end
        semi = (idx - 1) % 12;
        oct  = (idx - 1) / 12;
        case (semi)
            0:       base = 32'd19224;
            1:       base = 32'd20367;
            2:       base = 32'd21578;
            3:       base = 32'd22861;
            4:       base = 32'd24221;
            5:       base = 32'd25661;
            6:       base = 32'd27187;
            7:       base = 32'd28803;
            8:       base = 32'd30516;
            9:       base = 32'd32331;
            10:      base = 32'd34253;
            default: base = 32'd36290;
        endcase
        return base >> (5 - oct);
    endfunction

endpackage

// File: rtl/note_player_if.sv
// Note handshake between the song reader (master) and the note player (slave).
interface note_player_if;
    import note_pkg::*;

    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              player_ready;
    logic              done_with_note;

    modport master (
        output note,
        output duration,
        output new_note,
        input  player_ready,
        input  done_with_note
    );

    modport slave (
        input  note,
        input  duration,
        input  new_note,
        output player_ready,
        output done_with_note
    );

endinterface

// File: rtl/note_player_frequency_rom.sv
// Synchronous 64-entry step-size ROM: one cycle from addr to dout.
module frequency_rom
    import note_pkg::*;
#(
    parameter int PHASE_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NOTE_W-1:0]  addr,
    output logic [PHASE_W-1:0] dout
);

    logic [PHASE_W-1:0] rom [ROM_DEPTH];
    logic [PHASE_W-1:0] dout_q;
    logic [PHASE_W-1:0] dout_d;

    generate
        for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            assign rom[gi] = PHASE_W'(np_rom_step(gi));
        end
    endgenerate

    always_comb begin
        dout_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/note_player.sv
// Accepts one note at a time from the song reader and plays it as a square wave
// for the requested number of beats, producing one sample per codec request.
module note_player
    import note_pkg::*;
#(
    parameter int                          PHASE_W = 20,
    parameter logic signed [SAMPLE_W-1:0]  AMP     = 16'sh2000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    note_player_if.slave               bus,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready
);

    np_state_t                  state_q, state_d;
    logic [NOTE_W-1:0]          note_q, note_d;
    logic [DUR_W-1:0]           beats_left_q, beats_left_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [PHASE_W-1:0]         step_q, step_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       sample_ready_q, sample_ready_d;

    logic [PHASE_W-1:0]         rom_dout;
    logic [PHASE_W-1:0]         phase_sum;
    logic                       beat_hit;
    logic                       sample_hit;

    // Addressed with the note about to be latched so the step is ready by the end of LOAD.
    frequency_rom #(
        .PHASE_W (PHASE_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (note_d),
        .dout  (rom_dout)
    );

    assign phase_sum  = phase_q + step_q;
    assign beat_hit   = beat && play_enable;
    assign sample_hit = generate_next_sample && play_enable;

    always_comb begin
        state_d        = state_q;
        note_d         = note_q;
        beats_left_d   = beats_left_q;
        phase_d        = phase_q;
        step_d         = step_q;
        sample_d       = sample_q;
        sample_ready_d = 1'b0;

        case (state_q)
            NP_IDLE: begin
                if (bus.new_note) begin
                    note_d       = bus.note;
                    beats_left_d = bus.duration;
                    state_d      = NP_LOAD;
                end
            end
            NP_LOAD: begin
                step_d  = rom_dout;
                phase_d = '0;
                state_d = (beats_left_q == '0) ? NP_DONE : NP_PLAY;
            end
            NP_PLAY: begin
                if (sample_hit) begin
                    phase_d        = phase_sum;
                    sample_ready_d = 1'b1;
                    if (note_q == NOTE_REST) begin
                        sample_d = '0;
                    end else begin
                        sample_d = phase_sum[PHASE_W-1] ? -AMP : AMP;
                    end
                end
                // The final beat still lets a same-cycle sample request through.
                if (beat_hit && (beats_left_q != '0)) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == DUR_W'(1)) begin
                        state_d = NP_DONE;
                    end
                end
            end
            NP_DONE: begin
                state_d  = NP_IDLE;
                sample_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= NP_IDLE;
            note_q         <= NOTE_REST;
            beats_left_q   <= '0;
            phase_q        <= '0;
            step_q         <= '0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            note_q         <= note_d;
            beats_left_q   <= beats_left_d;
            phase_q        <= phase_d;
            step_q         <= step_d;
            sample_q       <= sample_d;
            sample_ready_q <= sample_ready_d;
        end
    end

    assign bus.player_ready   = (state_q == NP_IDLE);
    assign bus.done_with_note = (state_q == NP_DONE);
    assign sample_out         = sample_q;
    assign new_sample_ready   = sample_ready_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: a note-level reference model checked every cycle,
// plus hand-computed expectations for handshake timing and square-wave signs.
module tb_note_player;
    import note_pkg::*;

    localparam int PHASE_W = 20;
    localparam int PH_MOD  = 1 << PHASE_W;
    localparam int AMP_I   = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic play_enable = 1'b0;
    logic beat = 1'b0;
    logic gen = 1'b0;
    logic signed [15:0] sample_out;
    logic new_sample_ready;

    note_player_if bus ();

    always #5 clk = ~clk;

    note_player #(
        .PHASE_W (PHASE_W),
        .AMP     (16'sh2000)
    ) dut (
        .clk                  (clk),
        .reset                (rst_n),
        .play_enable          (play_enable),
        .beat                 (beat),
        .generate_next_sample (gen),
        .bus                  (bus),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: a note is either being set up, sounding, or finishing.
    int cyc = 0;
    int m_phase = 0, m_step = 0, m_beats = 0, m_note = 0;
    bit m_loading = 0, m_playing = 0, m_closing = 0;
    bit exp_ready = 1, exp_done = 0, exp_nsr = 0;
    int exp_sample = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_loading = 0; m_playing = 0; m_closing = 0;
            m_phase = 0; m_step = 0; m_beats = 0; m_note = 0;
            exp_sample = 0; exp_nsr = 0;
        end else begin
            exp_nsr = 0;
            if (m_playing && play_enable && gen) begin
                m_phase = (m_phase + m_step) % PH_MOD;
                exp_nsr = 1;
                if (m_note == 0) exp_sample = 0;
                else exp_sample = (m_phase >= PH_MOD / 2) ? -AMP_I : AMP_I;
            end
            if (m_closing) begin
                m_closing = 0;
                exp_sample = 0;
            end else if (m_loading) begin
                m_loading = 0;
                m_phase = 0;
                m_step = int'(np_rom_step(m_note));
                if (m_beats == 0) m_closing = 1;
                else m_playing = 1;
            end else if (m_playing) begin
                if (play_enable && beat) begin
                    m_beats--;
                    if (m_beats == 0) begin
                        m_playing = 0;
                        m_closing = 1;
                    end
                end
            end else if (bus.new_note) begin
                m_note = int'(bus.note);
                m_beats = int'(bus.duration);
                m_loading = 1;
            end
        end
        exp_ready = !(m_loading || m_playing || m_closing);
        exp_done  = m_closing;
    end

    int done_cnt = 0, nsr_cnt = 0, last_done_cyc = -1;
    int samp_log[$];

    initial forever begin
        @(negedge clk);
        chk("player_ready", int'(bus.player_ready), int'(exp_ready));
        chk("done_with_note", int'(bus.done_with_note), int'(exp_done));
        chk("new_sample_ready", int'(new_sample_ready), int'(exp_nsr));
        chk("sample_out", int'(sample_out), exp_sample);
        if (bus.done_with_note) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (new_sample_ready) begin
            nsr_cnt++;
            samp_log.push_back(int'(sample_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int d, output int a);
        bus.note = 6'(n);
        bus.duration = 6'(d);
        bus.new_note = 1'b1;
        tick();
        a = cyc;
        bus.new_note = 1'b0;
        chk("ready_low_after_accept", int'(bus.player_ready), 0);
    endtask

    task automatic req();
        gen = 1'b1;
        tick();
        gen = 1'b0;
        tick();
    endtask

    task automatic beat_pulse(output int b);
        beat = 1'b1;
        tick();
        b = cyc;
        beat = 1'b0;
    endtask

    int a, b1, b2, d0, n0;

    initial begin
        bus.note = '0;
        bus.duration = '0;
        bus.new_note = 1'b0;
        repeat (3) tick();
        chk("reset_ready", int'(bus.player_ready), 1);
        chk("reset_done", int'(bus.done_with_note), 0);
        chk("reset_sample", int'(sample_out), 0);
        chk("reset_nsr", int'(new_sample_ready), 0);
        rst_n = 1'b1;
        play_enable = 1'b1;
        tick();

        // 1: reset mid-note aborts quietly
        samp_log.delete();
        send(49, 5, a);
        tick();
        repeat (3) req();
        chk("t1_nsamples", samp_log.size(), 3);
        if (samp_log.size() > 0) chk("t1_first_sample", samp_log[0], AMP_I);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        chk("t1_ready", int'(bus.player_ready), 1);
        chk("t1_sample", int'(sample_out), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_no_done", done_cnt - d0, 0);

        // 2: two beats, final beat coincides with a sample request
        d0 = done_cnt;
        send(49, 2, a);
        repeat (9) tick();
        beat_pulse(b1);
        chk("t2_not_done_after_1", int'(bus.done_with_note), 0);
        repeat (9) tick();
        beat = 1'b1;
        gen = 1'b1;
        tick();
        b2 = cyc;
        beat = 1'b0;
        gen = 1'b0;
        chk("t2_done_pulse", int'(bus.done_with_note), 1);
        chk("t2_ready_in_done", int'(bus.player_ready), 0);
        chk("t2_nsr_in_done", int'(new_sample_ready), 1);
        tick();
        chk("t2_ready_after", int'(bus.player_ready), 1);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_done_cycle", last_done_cyc, b2);

        // 3: rest still pulses new_sample_ready with zero samples
        send(0, 1, a);
        tick();
        n0 = nsr_cnt;
        samp_log.delete();
        repeat (4) req();
        beat_pulse(b1);
        tick();
        chk("t3_nsamples", nsr_cnt - n0, 4);
        for (int i = 0; i < samp_log.size(); i++) chk("t3_rest_sample", samp_log[i], 0);

        // 4: zero duration goes straight to done
        d0 = done_cnt;
        n0 = nsr_cnt;
        send(5, 0, a);
        gen = 1'b1;
        tick();
        chk("t4_done_at_T2", int'(bus.done_with_note), 1);
        tick();
        gen = 1'b0;
        chk("t4_ready_at_T3", int'(bus.player_ready), 1);
        chk("t4_done_cycle", last_done_cyc, a + 1);
        chk("t4_no_samples", nsr_cnt - n0, 0);
        chk("t4_done_count", done_cnt - d0, 1);

        // 5: pause freezes beats and samples
        d0 = done_cnt;
        send(20, 2, a);
        tick();
        play_enable = 1'b0;
        n0 = nsr_cnt;
        for (int i = 0; i < 3; i++) begin
            beat = 1'b1;
            gen = 1'b1;
            tick();
            beat = 1'b0;
            gen = 1'b0;
            tick();
        end
        chk("t5_paused_no_done", done_cnt - d0, 0);
        chk("t5_paused_no_samples", nsr_cnt - n0, 0);
        chk("t5_paused_busy", int'(bus.player_ready), 0);
        play_enable = 1'b1;
        repeat (2) tick();
        beat_pulse(b1);
        chk("t5_one_beat_left", int'(bus.done_with_note), 0);
        repeat (3) tick();
        beat_pulse(b2);
        chk("t5_done_after_resume", int'(bus.done_with_note), 1);
        tick();
        chk("t5_done_count", done_cnt - d0, 1);

        // 6: stray new_note ignored while busy; phase wraps with step 0xF0000
        samp_log.delete();
        send(63, 1, a);
        bus.note = 6'd7;
        bus.duration = 6'd9;
        bus.new_note = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 4) bus.new_note = 1'b0;
            req();
        end
        bus.new_note = 1'b0;
        beat_pulse(b1);
        tick();
        chk("t6_nsamples", samp_log.size(), 16);
        for (int i = 0; i < samp_log.size(); i++)
            chk("t6_wrap_sign", samp_log[i], (i < 8) ? -AMP_I : AMP_I);
        chk("t6_idle_after", int'(bus.player_ready), 1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
